// File: rtl/pdes_arb_pkg.sv
// Shared helpers for the PDES port arbiters: width sizing and one-hot decode.
package pdes_arb_pkg;

  // onehot() is sized for the widest arbiter we build; callers cast down to NR bits.
  localparam int ONEHOT_W = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [ONEHOT_W-1:0] onehot(input int idx, input int nr);
    logic [ONEHOT_W-1:0] v;
    v = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      v[i] = (i == idx) && (idx < nr);
    end
    return v;
  endfunction

endpackage

// File: rtl/burst_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req after ptr, wrapping at NR.
module rr_pick #(
  parameter int NR = 4,
  localparam int IW = $clog2(NR)
) (
  input  logic [NR-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int          pos;
  logic [IW-1:0] pos_idx;
  logic        found;

  // Wrap with a modulo on NR so non-power-of-two sizes never select a phantom line.
  always_comb begin
    idx     = '0;
    any     = |req;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= NR; k++) begin
      pos     = (int'(ptr) + k) % NR;
      pos_idx = IW'(pos);
      if (!found && req[pos_idx]) begin
        idx   = pos_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Sticky round-robin arbiter with a bounded burst under contention,
// a stall freeze and a new-grant pulse.
module burst_rr_arbiter
  import pdes_arb_pkg::*;
#(
  parameter int NR        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NR-1:0]         req,
  input  logic                  stall,
  output logic [NR-1:0]         vgnt,
  output logic [$clog2(NR)-1:0] egnt,
  output logic                  eval,
  output logic                  new_gnt
);

  localparam int IW = $clog2(NR);
  localparam int CW = clog2_min1(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

  logic [IW-1:0] last_gnt;
  logic          last_vld;
  logic [CW-1:0] cnt;

  logic [NR-1:0] last_oh;
  logic [NR-1:0] gnt_oh;
  logic [NR-1:0] others;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] gnt_idx;
  logic          pick_any;
  logic          burst_ok;
  logic          hold;

  rr_pick #(.NR(NR)) u_pick (
    .req (req),
    .ptr (last_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The holder keeps the line unless its burst is spent and someone else is waiting.
  always_comb begin
    last_oh  = NR'(onehot(int'(last_gnt), NR));
    others   = req & ~last_oh;
    burst_ok = (MAX_BURST == 0) || (cnt < BURST_LIM) || (others == '0);
    hold     = last_vld && req[last_gnt] && burst_ok;
    gnt_idx  = hold ? last_gnt : pick_idx;
    gnt_oh   = NR'(onehot(int'(gnt_idx), NR));
    eval     = pick_any;
    new_gnt  = eval && !hold;
    egnt     = reset ? '0 : gnt_idx;
    vgnt     = (eval && !reset) ? gnt_oh : '0;
  end

  // Idle cycles drop the burst but keep the rotation pointer where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= IW'(NR - 1);
      last_vld <= 1'b0;
      cnt      <= '0;
    end else if (!stall) begin
      if (eval) begin
        last_gnt <= gnt_idx;
        last_vld <= 1'b1;
        if (hold) begin
          cnt <= (cnt >= BURST_LIM) ? BURST_LIM : cnt + CW'(1);
        end else begin
          cnt <= CW'(1);
        end
      end else begin
        last_vld <= 1'b0;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter: three instances cover the bounded-burst,
// unlimited-sticky and non-power-of-two configurations.
module tb_burst_rr_arbiter;

  logic clk;
  logic reset;

  logic [3:0] req_a;
  logic       stall_a;
  logic [3:0] vgnt_a;
  logic [1:0] egnt_a;
  logic       eval_a;
  logic       new_a;

  logic [3:0] req_b;
  logic       stall_b;
  logic [3:0] vgnt_b;
  logic [1:0] egnt_b;
  logic       eval_b;
  logic       new_b;

  logic [4:0] req_c;
  logic       stall_c;
  logic [4:0] vgnt_c;
  logic [2:0] egnt_c;
  logic       eval_c;
  logic       new_c;

  int checks;
  int errors;

  burst_rr_arbiter #(.NR(4), .MAX_BURST(3)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .stall(stall_a),
    .vgnt(vgnt_a), .egnt(egnt_a), .eval(eval_a), .new_gnt(new_a)
  );

  burst_rr_arbiter #(.NR(4), .MAX_BURST(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .stall(stall_b),
    .vgnt(vgnt_b), .egnt(egnt_b), .eval(eval_b), .new_gnt(new_b)
  );

  burst_rr_arbiter #(.NR(5), .MAX_BURST(4)) dut_c (
    .clk(clk), .reset(reset), .req(req_c), .stall(stall_c),
    .vgnt(vgnt_c), .egnt(egnt_c), .eval(eval_c), .new_gnt(new_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req_a   = '0;
    req_b   = '0;
    req_c   = '0;
    stall_a = 1'b0;
    stall_b = 1'b0;
    stall_c = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    req_a = 4'b1111;
    #1;
    checks++; if (vgnt_a !== 4'b0000) begin errors++; $display("[TB] FAIL rst_vgnt got %b exp 0000", vgnt_a); end
    checks++; if (egnt_a !== 2'd0) begin errors++; $display("[TB] FAIL rst_egnt got %0d exp 0", egnt_a); end
    checks++; if (eval_a !== 1'b1) begin errors++; $display("[TB] FAIL rst_eval got %b exp 1", eval_a); end
    checks++; if (new_a !== 1'b1) begin errors++; $display("[TB] FAIL rst_new got %b exp 1", new_a); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (egnt_a !== 2'd0) begin errors++; $display("[TB] FAIL rst_first_egnt got %0d exp 0", egnt_a); end
    checks++; if (vgnt_a !== 4'b0001) begin errors++; $display("[TB] FAIL rst_first_vgnt got %b exp 0001", vgnt_a); end
    req_a = '0;
    tick();
  endtask

  task automatic test_rotation();
    int   exp_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic exp_new;
    logic [3:0] exp_vgnt;
    do_reset();
    req_a = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      #1;
      exp_new  = (i % 3 == 0);
      exp_vgnt = 4'b0001 << exp_seq[i];
      checks++; if (egnt_a !== 2'(exp_seq[i])) begin errors++; $display("[TB] FAIL rot_egnt cyc %0d got %0d exp %0d", i + 1, egnt_a, exp_seq[i]); end
      checks++; if (new_a !== exp_new) begin errors++; $display("[TB] FAIL rot_new cyc %0d got %b exp %b", i + 1, new_a, exp_new); end
      checks++; if (vgnt_a !== exp_vgnt) begin errors++; $display("[TB] FAIL rot_vgnt cyc %0d got %b exp %b", i + 1, vgnt_a, exp_vgnt); end
      tick();
    end
    req_a = '0;
    tick();
  endtask

  task automatic test_solo_saturate();
    logic exp_new;
    do_reset();
    req_a = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_new = (i == 0);
      checks++; if (egnt_a !== 2'd0) begin errors++; $display("[TB] FAIL solo_egnt cyc %0d got %0d exp 0", i + 1, egnt_a); end
      checks++; if (new_a !== exp_new) begin errors++; $display("[TB] FAIL solo_new cyc %0d got %b exp %b", i + 1, new_a, exp_new); end
      tick();
    end
    req_a = 4'b0011;
    #1;
    checks++; if (egnt_a !== 2'd1) begin errors++; $display("[TB] FAIL sat_rotate_egnt got %0d exp 1", egnt_a); end
    checks++; if (new_a !== 1'b1) begin errors++; $display("[TB] FAIL sat_rotate_new got %b exp 1", new_a); end
    tick();
    req_a = '0;
    tick();
  endtask

  task automatic test_holder_drop();
    do_reset();
    req_a = 4'b0101;
    #1;
    checks++; if (egnt_a !== 2'd0) begin errors++; $display("[TB] FAIL drop_first_egnt got %0d exp 0", egnt_a); end
    tick();
    #1;
    checks++; if (new_a !== 1'b0) begin errors++; $display("[TB] FAIL drop_hold_new got %b exp 0", new_a); end
    req_a = 4'b0100;
    #1;
    checks++; if (egnt_a !== 2'd2) begin errors++; $display("[TB] FAIL drop_egnt got %0d exp 2", egnt_a); end
    checks++; if (vgnt_a !== 4'b0100) begin errors++; $display("[TB] FAIL drop_vgnt got %b exp 0100", vgnt_a); end
    checks++; if (new_a !== 1'b1) begin errors++; $display("[TB] FAIL drop_new got %b exp 1", new_a); end
    tick();
    #1;
    checks++; if (egnt_a !== 2'd2 || new_a !== 1'b0) begin errors++; $display("[TB] FAIL drop_next egnt %0d new %b exp 2 0", egnt_a, new_a); end
    req_a = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req_a = 4'b0011;
    #1;
    checks++; if (egnt_a !== 2'd0 || new_a !== 1'b1) begin errors++; $display("[TB] FAIL stall_first egnt %0d new %b exp 0 1", egnt_a, new_a); end
    tick();
    stall_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (egnt_a !== 2'd0 || new_a !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold cyc %0d egnt %0d new %b exp 0 0", i, egnt_a, new_a); end
      if (i == 2) begin
        req_a = 4'b0010;
        #1;
        checks++; if (egnt_a !== 2'd1 || new_a !== 1'b1) begin errors++; $display("[TB] FAIL stall_reqchg egnt %0d new %b exp 1 1", egnt_a, new_a); end
        req_a = 4'b0011;
        #1;
        checks++; if (egnt_a !== 2'd0) begin errors++; $display("[TB] FAIL stall_reqback egnt %0d exp 0", egnt_a); end
      end
      tick();
    end
    stall_a = 1'b0;
    #1;
    checks++; if (egnt_a !== 2'd0 || new_a !== 1'b0) begin errors++; $display("[TB] FAIL stall_resume1 egnt %0d new %b exp 0 0", egnt_a, new_a); end
    tick();
    #1;
    checks++; if (egnt_a !== 2'd0 || new_a !== 1'b0) begin errors++; $display("[TB] FAIL stall_resume2 egnt %0d new %b exp 0 0", egnt_a, new_a); end
    tick();
    #1;
    checks++; if (egnt_a !== 2'd1 || new_a !== 1'b1) begin errors++; $display("[TB] FAIL stall_rotate egnt %0d new %b exp 1 1", egnt_a, new_a); end
    req_a = '0;
    tick();
  endtask

  task automatic test_unlimited();
    logic exp_new;
    do_reset();
    req_b = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp_new = (i == 0);
      checks++; if (egnt_b !== 2'd0 || new_b !== exp_new) begin errors++; $display("[TB] FAIL unl_hold cyc %0d egnt %0d new %b exp 0 %b", i + 1, egnt_b, new_b, exp_new); end
      tick();
    end
    req_b = 4'b0000;
    #1;
    checks++; if (eval_b !== 1'b0 || vgnt_b !== 4'b0000) begin errors++; $display("[TB] FAIL unl_idle eval %b vgnt %b exp 0 0000", eval_b, vgnt_b); end
    tick();
    req_b = 4'b1111;
    #1;
    checks++; if (egnt_b !== 2'd1 || new_b !== 1'b1) begin errors++; $display("[TB] FAIL unl_after_idle egnt %0d new %b exp 1 1", egnt_b, new_b); end
    req_b = '0;
    tick();
  endtask

  task automatic test_nr5();
    do_reset();
    req_c = 5'b10000;
    #1;
    checks++; if (egnt_c !== 3'd4) begin errors++; $display("[TB] FAIL nr5_line4 egnt %0d exp 4", egnt_c); end
    tick();
    req_c = 5'b10001;
    #1;
    checks++; if (egnt_c !== 3'd4 || new_c !== 1'b0) begin errors++; $display("[TB] FAIL nr5_hold egnt %0d new %b exp 4 0", egnt_c, new_c); end
    req_c = 5'b00001;
    #1;
    checks++; if (egnt_c !== 3'd0) begin errors++; $display("[TB] FAIL nr5_wrap egnt %0d exp 0", egnt_c); end
    checks++; if (vgnt_c !== 5'b00001 || new_c !== 1'b1) begin errors++; $display("[TB] FAIL nr5_wrap_vgnt vgnt %b new %b exp 00001 1", vgnt_c, new_c); end
    tick();
    req_c = 5'b00010;
    #1;
    checks++; if (egnt_c !== 3'd1) begin errors++; $display("[TB] FAIL nr5_line1 egnt %0d exp 1", egnt_c); end
    tick();
    req_c = 5'b00011;
    #1;
    checks++; if (egnt_c !== 3'd1 || new_c !== 1'b0) begin errors++; $display("[TB] FAIL nr5_prerst egnt %0d new %b exp 1 0", egnt_c, new_c); end
    reset = 1'b1;
    #1;
    checks++; if (vgnt_c !== 5'b00000 || egnt_c !== 3'd0) begin errors++; $display("[TB] FAIL nr5_async_rst vgnt %b egnt %0d exp 00000 0", vgnt_c, egnt_c); end
    checks++; if (eval_c !== 1'b1) begin errors++; $display("[TB] FAIL nr5_rst_eval got %b exp 1", eval_c); end
    reset = 1'b0;
    #1;
    checks++; if (egnt_c !== 3'd0 || vgnt_c !== 5'b00001 || new_c !== 1'b1) begin errors++; $display("[TB] FAIL nr5_post_rst egnt %0d vgnt %b new %b exp 0 00001 1", egnt_c, vgnt_c, new_c); end
    tick();
    req_c = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    req_a   = '0;
    req_b   = '0;
    req_c   = '0;
    stall_a = 1'b0;
    stall_b = 1'b0;
    stall_c = 1'b0;
    test_reset();
    test_rotation();
    test_solo_saturate();
    test_holder_drop();
    test_stall();
    test_unlimited();
    test_nr5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
